router_fsm: RTL and testbench
=============================

ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clock `clock`, reset `resetn`.
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: resetn  input  1  synchronous active-low reset, sampled on the rising edge of clock.
REQ-004 Port: pkt_valid  input  1  high while a packet byte (header/payload) is presented upstream.
REQ-005 Port: data_in  input  2  destination address, equal to header bits [1:0].
REQ-006 Port: parity_done  input  1  parity byte has been captured downstream.
REQ-007 Port: low_pkt_valid  input  1  pkt_valid fell while a FIFO was full.
REQ-008 Port: fifo_full  input  1  full flag of the currently selected FIFO.
REQ-009 Port: fifo_empty_0/1/2  input  1 each  empty flags of FIFOs 0..2.
REQ-010 Port: soft_reset_0/1/2  input  1 each  per-FIFO soft-reset pulses.
REQ-011 Port: busy  output  1  stall request to the packet source.
REQ-012 Port: detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg  outputs  1 each  state decodes.
REQ-013 Port: write_enb_reg  output  1  FIFO write enable.

Function
REQ-014 The block SHALL be a Moore FSM with 8 states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR and WAIT_TILL_EMPTY.
REQ-015 The block SHALL contain a 2-bit addr_q register that loads data_in when state==DECODE_ADDRESS and pkt_valid==1; addr_q SHALL hold its value at all other times.
REQ-016 sel_empty SHALL be fifo_empty_[addr] in DECODE_ADDRESS, with addr taken from data_in; in all other states it SHALL be fifo_empty_[addr_q].
REQ-017 Transitions out of DECODE_ADDRESS SHALL be:
- pkt_valid, data_in!=3, sel_empty -> LOAD_FIRST_DATA;
- pkt_valid, data_in!=3, !sel_empty -> WAIT_TILL_EMPTY;
- otherwise stay.
REQ-018 Address 3 SHALL be dropped: the FSM stays in DECODE_ADDRESS.
REQ-019 WAIT_TILL_EMPTY SHALL go to LOAD_FIRST_DATA when sel_empty==1, and otherwise stay.
REQ-020 LOAD_FIRST_DATA SHALL go to LOAD_DATA unconditionally after 1 cycle.
REQ-021 Transitions out of LOAD_DATA SHALL be, in priority order:
- fifo_full -> FIFO_FULL_STATE;
- !pkt_valid -> LOAD_PARITY;
- otherwise stay.
REQ-022 FIFO_FULL_STATE SHALL go to LOAD_AFTER_FULL when !fifo_full, and otherwise stay.
REQ-023 Transitions out of LOAD_AFTER_FULL SHALL be, in priority order:
- parity_done -> DECODE_ADDRESS;
- low_pkt_valid -> LOAD_PARITY;
- otherwise -> LOAD_DATA.
REQ-024 LOAD_PARITY SHALL go to CHECK_PARITY_ERROR unconditionally after 1 cycle.
REQ-025 Transitions out of CHECK_PARITY_ERROR SHALL be:
- fifo_full -> FIFO_FULL_STATE;
- otherwise -> DECODE_ADDRESS.
REQ-026 Soft reset: soft_reset_[addr_q]==1 in any state other than DECODE_ADDRESS SHALL force DECODE_ADDRESS on the next edge, overriding all other transitions.
REQ-027 Soft-reset pulses on the non-selected ports SHALL be ignored.
REQ-028 Output decodes SHALL be combinational from the state register alone:
- detect_add = DECODE_ADDRESS;
- lfd_state = LOAD_FIRST_DATA;
- ld_state = LOAD_DATA;
- full_state = FIFO_FULL_STATE;
- laf_state = LOAD_AFTER_FULL;
- rst_int_reg = CHECK_PARITY_ERROR.
REQ-029 write_enb_reg SHALL be 1 exactly in LOAD_DATA, LOAD_AFTER_FULL and LOAD_PARITY.
REQ-030 busy SHALL be 1 in every state except DECODE_ADDRESS and LOAD_DATA.
REQ-031 Exactly one of detect_add, lfd_state, ld_state, full_state, laf_state and rst_int_reg SHALL be high, except in LOAD_PARITY and WAIT_TILL_EMPTY, where all six SHALL be low.
REQ-032 Header-to-first-write latency SHALL be as follows:
- the header is sampled in DECODE_ADDRESS at edge N;
- lfd_state is high in cycle N+1;
- write_enb_reg is high from cycle N+2.

Reset
REQ-033 When resetn==0 at a rising edge, the block SHALL set state = DECODE_ADDRESS and addr_q = 0, overriding soft_reset and all other inputs.
REQ-034 Output values after reset SHALL be: detect_add = 1; all other outputs, including busy and write_enb_reg, = 0.
REQ-035 Asserting reset mid-packet, in any state, SHALL return the block to DECODE_ADDRESS on that same edge.

Verification
REQ-036 Normal packet, port 1:
- stimulus: fifo_empty_1=1, data_in=2'b01 with pkt_valid=1 for 10 cycles, then pkt_valid=0;
- required sequence: DECODE -> LFD(1 cycle) -> LD(9 cycles) -> LOAD_PARITY -> CHECK_PARITY_ERROR -> DECODE;
- write_enb_reg high for exactly 10 cycles.
REQ-037 Busy FIFO:
- stimulus: data_in=2'b10, pkt_valid=1, fifo_empty_2=0 for 5 cycles, then 1;
- required response: WAIT_TILL_EMPTY for 5 cycles with busy=1 and write_enb_reg=0, then LOAD_FIRST_DATA.
REQ-038 Full mid-payload:
- stimulus: fifo_full=1 for 3 cycles while in LD, with parity_done=0 and low_pkt_valid=0;
- required sequence: FIFO_FULL_STATE for 3 cycles (busy=1, write_enb_reg=0) -> LOAD_AFTER_FULL -> LD.
REQ-039 Soft reset:
- stimulus: in LD with addr_q=1, pulse soft_reset_0 -> no effect;
- stimulus: pulse soft_reset_1 -> DECODE_ADDRESS on the next edge.
REQ-040 Invalid address and reset:
- stimulus: data_in=2'b11 with pkt_valid=1 -> FSM stays in DECODE_ADDRESS and addr_q is unchanged;
- stimulus: resetn=0 during FIFO_FULL_STATE -> detect_add=1 and busy=0 after that edge.

Source files
------------

// File: rtl/router_fsm.sv
// ---------------------------------------------------------------------------
// router_fsm
//
// Control FSM of a three-port packet router. It decodes the destination
// address from the header byte, waits for the chosen output FIFO to drain
// if needed, and steers the FIFO write enable through the header, payload
// and parity bytes. It also stalls the packet source while a FIFO is full
// and restarts cleanly on a per-FIFO soft reset.
//
// Ports
//   clock          in   rising-edge clock for all state
//   resetn         in   synchronous active-low reset
//   pkt_valid      in   a header/payload byte is presented upstream
//   data_in[1:0]   in   destination address (header bits [1:0])
//   parity_done    in   parity byte captured downstream
//   low_pkt_valid  in   pkt_valid fell while a FIFO was full
//   fifo_full      in   full flag of the selected FIFO
//   fifo_empty_0/1/2  in  empty flags of FIFOs 0..2
//   soft_reset_0/1/2  in  per-FIFO soft-reset pulses
//   busy           out  stall request to the packet source
//   detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg
//                  out  state decodes
//   write_enb_reg  out  FIFO write enable
// ---------------------------------------------------------------------------
module router_fsm (
   input  logic       clock,
   input  logic       resetn,
   input  logic       pkt_valid,
   input  logic [1:0] data_in,
   input  logic       parity_done,
   input  logic       low_pkt_valid,
   input  logic       fifo_full,
   input  logic       fifo_empty_0,
   input  logic       fifo_empty_1,
   input  logic       fifo_empty_2,
   input  logic       soft_reset_0,
   input  logic       soft_reset_1,
   input  logic       soft_reset_2,
   output logic       busy,
   output logic       detect_add,
   output logic       lfd_state,
   output logic       ld_state,
   output logic       full_state,
   output logic       laf_state,
   output logic       rst_int_reg,
   output logic       write_enb_reg
);

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      FIFO_FULL_STATE    = 3'd3,
      LOAD_AFTER_FULL    = 3'd4,
      LOAD_PARITY        = 3'd5,
      CHECK_PARITY_ERROR = 3'd6,
      WAIT_TILL_EMPTY    = 3'd7
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [1:0] addr_q;
   logic [1:0] addr_d;

   // Address 3 is not a real port; a zero in slot 3 keeps the lookup in
   // range and makes that address never look empty.
   logic [3:0] empty_vec;
   logic [2:0] soft_reset_vec;
   logic [2:0] soft_hit;
   logic [1:0] addr_sel;
   logic       sel_empty;
   logic       soft_reset_sel;
   logic       addr_valid;

   assign empty_vec      = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
   assign soft_reset_vec = {soft_reset_2, soft_reset_1, soft_reset_0};

   // Only the soft reset of the port currently latched in addr_q matters.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_soft_hit
         assign soft_hit[gi] = soft_reset_vec[gi] && (addr_q == 2'(gi));
      end
   endgenerate

   assign soft_reset_sel = |soft_hit;

   // While decoding, the header has not been latched yet, so the empty flag
   // must be looked up with the live address bits.
   assign addr_sel   = (state_q == DECODE_ADDRESS) ? data_in : addr_q;
   assign sel_empty  = empty_vec[addr_sel];
   assign addr_valid = (data_in != 2'd3);

   // ------------------------------------------------------------------
   // State and address registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= DECODE_ADDRESS;
         addr_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;

      unique case (state_q)
         DECODE_ADDRESS: begin
            // A dropped header (address 3) leaves addr_q untouched so the
            // previous port's soft-reset selection stays meaningful.
            if (pkt_valid && addr_valid) begin
               addr_d  = data_in;
               state_d = sel_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
         end
         WAIT_TILL_EMPTY: begin
            if (sel_empty) begin
               state_d = LOAD_FIRST_DATA;
            end
         end
         LOAD_FIRST_DATA: begin
            state_d = LOAD_DATA;
         end
         LOAD_DATA: begin
            if (fifo_full) begin
               state_d = FIFO_FULL_STATE;
            end else if (!pkt_valid) begin
               state_d = LOAD_PARITY;
            end
         end
         FIFO_FULL_STATE: begin
            if (!fifo_full) begin
               state_d = LOAD_AFTER_FULL;
            end
         end
         LOAD_AFTER_FULL: begin
            if (parity_done) begin
               state_d = DECODE_ADDRESS;
            end else if (low_pkt_valid) begin
               state_d = LOAD_PARITY;
            end else begin
               state_d = LOAD_DATA;
            end
         end
         LOAD_PARITY: begin
            state_d = CHECK_PARITY_ERROR;
         end
         CHECK_PARITY_ERROR: begin
            state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
         end
         default: begin
            state_d = DECODE_ADDRESS;
         end
      endcase

      // Soft reset of the active port aborts the packet from any state.
      if ((state_q != DECODE_ADDRESS) && soft_reset_sel) begin
         state_d = DECODE_ADDRESS;
      end
   end

   // ------------------------------------------------------------------
   // Moore output decodes
   // ------------------------------------------------------------------
   always_comb begin
      detect_add    = 1'b0;
      lfd_state     = 1'b0;
      ld_state      = 1'b0;
      full_state    = 1'b0;
      laf_state     = 1'b0;
      rst_int_reg   = 1'b0;
      write_enb_reg = 1'b0;
      busy          = 1'b1;

      unique case (state_q)
         DECODE_ADDRESS: begin
            detect_add = 1'b1;
            busy       = 1'b0;
         end
         LOAD_FIRST_DATA: begin
            lfd_state = 1'b1;
         end
         LOAD_DATA: begin
            ld_state      = 1'b1;
            write_enb_reg = 1'b1;
            busy          = 1'b0;
         end
         FIFO_FULL_STATE: begin
            full_state = 1'b1;
         end
         LOAD_AFTER_FULL: begin
            laf_state     = 1'b1;
            write_enb_reg = 1'b1;
         end
         LOAD_PARITY: begin
            write_enb_reg = 1'b1;
         end
         CHECK_PARITY_ERROR: begin
            rst_int_reg = 1'b1;
         end
         WAIT_TILL_EMPTY: begin
            busy = 1'b1;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_router_fsm.sv
// ---------------------------------------------------------------------------
// tb_router_fsm
//
// Self-checking bench for router_fsm. A packet-level reference model tracks
// which phase of a packet the router should be in and which port is latched;
// a compare process checks every output against that model on each falling
// edge. Directed scenarios add hand-computed literal expectations.
// Output vector order: {busy, detect_add, lfd_state, ld_state, full_state,
// laf_state, rst_int_reg, write_enb_reg}.
// ---------------------------------------------------------------------------
module tb_router_fsm;

   logic       clock = 1'b0;
   logic       resetn;
   logic       pkt_valid;
   logic [1:0] data_in;
   logic       parity_done;
   logic       low_pkt_valid;
   logic       fifo_full;
   logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
   logic       soft_reset_0, soft_reset_1, soft_reset_2;
   logic       busy, detect_add, lfd_state, ld_state, full_state;
   logic       laf_state, rst_int_reg, write_enb_reg;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   router_fsm dut (
      .clock         (clock),
      .resetn        (resetn),
      .pkt_valid     (pkt_valid),
      .data_in       (data_in),
      .parity_done   (parity_done),
      .low_pkt_valid (low_pkt_valid),
      .fifo_full     (fifo_full),
      .fifo_empty_0  (fifo_empty_0),
      .fifo_empty_1  (fifo_empty_1),
      .fifo_empty_2  (fifo_empty_2),
      .soft_reset_0  (soft_reset_0),
      .soft_reset_1  (soft_reset_1),
      .soft_reset_2  (soft_reset_2),
      .busy          (busy),
      .detect_add    (detect_add),
      .lfd_state     (lfd_state),
      .ld_state      (ld_state),
      .full_state    (full_state),
      .laf_state     (laf_state),
      .rst_int_reg   (rst_int_reg),
      .write_enb_reg (write_enb_reg)
   );

   // ---------------- packet-phase reference model ----------------
   localparam int P_IDLE   = 0;  // waiting for a header
   localparam int P_HDR    = 1;  // header byte being written
   localparam int P_BODY   = 2;  // payload bytes
   localparam int P_STALL  = 3;  // FIFO full
   localparam int P_RESUME = 4;  // first cycle after full clears
   localparam int P_PAR    = 5;  // parity byte
   localparam int P_CHK    = 6;  // parity check
   localparam int P_WAIT   = 7;  // waiting for the FIFO to drain

   int   m_phase = P_IDLE;
   int   m_port  = 0;
   bit   m_valid = 1'b0;

   function automatic bit empty_of(input int p);
      case (p)
         0: return fifo_empty_0;
         1: return fifo_empty_1;
         2: return fifo_empty_2;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit soft_of(input int p);
      case (p)
         0: return soft_reset_0;
         1: return soft_reset_1;
         2: return soft_reset_2;
         default: return 1'b0;
      endcase
   endfunction

   // What the outputs must be for each packet phase.
   function automatic logic [7:0] expect_of(input int ph);
      case (ph)
         P_IDLE:   return 8'b0100_0000;
         P_HDR:    return 8'b1010_0000;
         P_BODY:   return 8'b0001_0001;
         P_STALL:  return 8'b1000_1000;
         P_RESUME: return 8'b1000_0101;
         P_PAR:    return 8'b1000_0001;
         P_CHK:    return 8'b1000_0010;
         default:  return 8'b1000_0000;
      endcase
   endfunction

   always @(posedge clock) begin
      if (!resetn) begin
         m_phase <= P_IDLE;
         m_port  <= 0;
         m_valid <= 1'b1;
      end else if (m_valid) begin
         if (m_phase != P_IDLE && soft_of(m_port)) begin
            m_phase <= P_IDLE;
         end else begin
            case (m_phase)
               P_IDLE: if (pkt_valid && int'(data_in) < 3) begin
                  m_port  <= int'(data_in);
                  m_phase <= empty_of(int'(data_in)) ? P_HDR : P_WAIT;
               end
               P_WAIT:   if (empty_of(m_port)) m_phase <= P_HDR;
               P_HDR:    m_phase <= P_BODY;
               P_BODY:   if (fifo_full) m_phase <= P_STALL;
                         else if (!pkt_valid) m_phase <= P_PAR;
               P_STALL:  if (!fifo_full) m_phase <= P_RESUME;
               P_RESUME: m_phase <= parity_done ? P_IDLE :
                                    (low_pkt_valid ? P_PAR : P_BODY);
               P_PAR:    m_phase <= P_CHK;
               default:  m_phase <= fifo_full ? P_STALL : P_IDLE;
            endcase
         end
      end
   end

   function automatic logic [7:0] outs();
      return {busy, detect_add, lfd_state, ld_state, full_state,
              laf_state, rst_int_reg, write_enb_reg};
   endfunction

   // Continuous comparison against the model.
   always @(negedge clock) begin
      if (m_valid) begin
         checks++;
         if (outs() !== expect_of(m_phase)) begin
            errors++;
            $display("FAIL model_cmp t=%0t phase=%0d got=%b expected=%b",
                     $time, m_phase, outs(), expect_of(m_phase));
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_outs(input string name, input logic [7:0] exp);
      checks++;
      if (outs() !== exp) begin
         errors++;
         $display("FAIL %s got=%b expected=%b", name, outs(), exp);
      end
   endtask

   task automatic chk_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   int n_we, n_ld, n_lfd, n_chk;

   initial begin
      resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0;
      parity_done = 1'b0; low_pkt_valid = 1'b0; fifo_full = 1'b0;
      fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
      soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;

      // Reset state
      step(); step();
      chk_outs("reset_outputs", 8'b0100_0000);
      resetn = 1'b1;
      step();
      chk_outs("idle_after_reset", 8'b0100_0000);
      $display("txn reset done");

      // Normal packet to port 1
      data_in = 2'd1; pkt_valid = 1'b1;
      n_we = 0; n_ld = 0; n_lfd = 0; n_chk = 0;
      for (int i = 0; i < 14; i++) begin
         if (i == 10) pkt_valid = 1'b0;
         step();
         if (i == 0) chk_outs("lfd_latency", 8'b1010_0000);
         if (i == 1) chk_outs("first_write", 8'b0001_0001);
         n_we  += int'(write_enb_reg);
         n_ld  += int'(ld_state);
         n_lfd += int'(lfd_state);
         n_chk += int'(rst_int_reg);
      end
      chk_int("pkt1_write_cycles", n_we, 10);
      chk_int("pkt1_ld_cycles", n_ld, 9);
      chk_int("pkt1_lfd_cycles", n_lfd, 1);
      chk_int("pkt1_chk_cycles", n_chk, 1);
      chk_outs("pkt1_back_idle", 8'b0100_0000);
      $display("txn normal packet port1 writes=%0d", n_we);

      // Busy FIFO on port 2
      fifo_empty_2 = 1'b0; data_in = 2'd2; pkt_valid = 1'b1;
      step();
      n_chk = 0;
      for (int i = 0; i < 5; i++) begin
         if (outs() === 8'b1000_0000) n_chk++;
         if (i == 4) fifo_empty_2 = 1'b1;
         step();
      end
      chk_int("wait_cycles", n_chk, 5);
      chk_outs("wait_to_lfd", 8'b1010_0000);
      step();
      chk_outs("port2_ld", 8'b0001_0001);
      $display("txn busy fifo wait_cycles=%0d", n_chk);

      // Full mid-payload
      fifo_full = 1'b1;
      n_chk = 0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin
            step();
            if (outs() === 8'b1000_1000) n_chk++;
            fifo_full = 1'b0;
         end else begin
            step();
            if (outs() === 8'b1000_1000) n_chk++;
         end
      end
      chk_int("full_cycles", n_chk, 3);
      step();
      chk_outs("laf", 8'b1000_0101);
      step();
      chk_outs("laf_to_ld", 8'b0001_0001);
      $display("txn full mid-payload full_cycles=%0d", n_chk);

      // Finish packet, then soft reset on port 1
      pkt_valid = 1'b0;
      step(); step(); step();
      chk_outs("port2_done", 8'b0100_0000);
      data_in = 2'd1; pkt_valid = 1'b1;
      step(); step();
      chk_outs("port1_ld", 8'b0001_0001);
      soft_reset_0 = 1'b1;
      step();
      soft_reset_0 = 1'b0;
      chk_outs("soft0_ignored", 8'b0001_0001);
      soft_reset_1 = 1'b1; pkt_valid = 1'b0;
      step();
      soft_reset_1 = 1'b0;
      chk_outs("soft1_abort", 8'b0100_0000);
      $display("txn soft reset");

      // Invalid address: dropped, addr stays at 1
      data_in = 2'd3; pkt_valid = 1'b1;
      step(); step(); step();
      chk_outs("addr3_dropped", 8'b0100_0000);
      chk_int("addr3_addr_hold", int'(dut.addr_q), 1);
      $display("txn invalid address");

      // Reset while in FIFO_FULL_STATE
      data_in = 2'd0;
      step(); step();
      chk_outs("port0_ld", 8'b0001_0001);
      fifo_full = 1'b1; soft_reset_0 = 1'b1;
      step();
      soft_reset_0 = 1'b0;
      chk_outs("soft0_abort", 8'b0100_0000);
      step(); step(); step();
      chk_outs("port0_full", 8'b1000_1000);
      resetn = 1'b0; soft_reset_0 = 1'b1;
      step();
      chk_outs("reset_from_full", 8'b0100_0000);
      chk_int("reset_addr", int'(dut.addr_q), 0);
      resetn = 1'b1; soft_reset_0 = 1'b0; fifo_full = 1'b0; pkt_valid = 1'b0;
      step(); step();
      chk_outs("idle_end", 8'b0100_0000);
      $display("txn reset mid-packet");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
